axis_red_pitaya_adc_capture: RTL

Receive-side counterpart of the Red Pitaya DAC streaming block. Registers the two 14-bit ADC channels every `aclk`, converts them to sign-extended two's complement, and on an armed trigger rising edge captures a programmed number of sample pairs. Samples go into a small FIFO that feeds an AXI4-Stream master, with `tlast` on the final pair. It sits between the ADC pins and the OFDM receive DSP chain.

---
 rtl/axis_red_pitaya_adc_capture.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_red_pitaya_adc_capture.sv
// Red Pitaya ADC capture: triggered burst of sample pairs into an AXI4-Stream.
// Define ADC_TEST_PATTERN_EN to replace the pin data with a counter pattern.
module axis_red_pitaya_adc_capture #(
  parameter int ADC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH_LOG2  = 4,
  parameter int CNT_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_a,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_b,
  output logic                        adc_csn,
  input  logic                        trigger,
  input  logic                        arm,
  input  logic [CNT_WIDTH-1:0]        cfg_length,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic                        busy,
  output logic                        overflow
);

  localparam int HW    = AXIS_TDATA_WIDTH / 2;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int EW    = AXIS_TDATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  function automatic logic [HW-1:0] conv(
    input logic [ADC_DATA_WIDTH-1:0] d
  );
    logic [ADC_DATA_WIDTH-1:0] c;
    c = {d[ADC_DATA_WIDTH-1], ~d[ADC_DATA_WIDTH-2:0]};
    return {{(HW-ADC_DATA_WIDTH){c[ADC_DATA_WIDTH-1]}}, c};
  endfunction

  logic [ADC_DATA_WIDTH-1:0]   a_q;
  logic [ADC_DATA_WIDTH-1:0]   b_q;
  logic                        trig_q;
  logic                        trig_prev_q;
  logic [HW-1:0]               fmt_a_q;
  logic [HW-1:0]               fmt_b_q;
  logic [AXIS_TDATA_WIDTH-1:0] pair;
  logic                        rise;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      a_q         <= '0;
      b_q         <= '0;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      a_q         <= adc_dat_a;
      b_q         <= adc_dat_b;
      trig_q      <= trigger;
      trig_prev_q <= trig_q;
    end
  end

`ifdef ADC_TEST_PATTERN_EN
  logic [HW-1:0] tp_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tp_q    <= '0;
      fmt_a_q <= '0;
      fmt_b_q <= '0;
    end else begin
      tp_q    <= tp_q + HW'(1);
      fmt_a_q <= tp_q;
      fmt_b_q <= ~tp_q;
    end
  end

  logic unused_pins;
  assign unused_pins = ^{a_q, b_q};
`else
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      fmt_a_q <= '0;
      fmt_b_q <= '0;
    end else begin
      fmt_a_q <= conv(a_q);
      fmt_b_q <= conv(b_q);
    end
  end
`endif

  assign pair = {fmt_b_q, fmt_a_q};
  assign rise = trig_q & ~trig_prev_q;

  state_t                      state_q;
  logic [CNT_WIDTH-1:0]        len_q;
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        ovf_q;
  logic                        fresh_q;
  logic                        pend_q;
  logic [AXIS_TDATA_WIDTH-1:0] last_q;
  logic                        busy_q;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_d;
  logic [PW-1:0] rd_ptr_d;
  logic [EW-1:0] head;
  logic [EW-1:0] wr_word;
  logic          empty;
  logic          full;
  logic          rd_en;
  logic          can_wr;
  logic          last_pair;
  logic          cap_wr;
  logic          pend_wr;
  logic          wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];
  assign rd_en = ~empty & m_axis_tready;

  // A pop in the same cycle frees the slot, so full+read still writes.
  assign can_wr    = ~full | rd_en;
  assign last_pair = (cnt_q == len_q - CNT_WIDTH'(1));
  assign cap_wr    = (state_q == S_CAPTURE) & can_wr;
  assign pend_wr   = (state_q == S_DONE) & pend_q & can_wr;
  assign wr_en     = cap_wr | pend_wr;
  assign wr_word   = pend_wr ? {1'b1, last_q} : {last_pair, pair};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fresh_q <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (arm && cfg_length != '0) begin
            state_q <= S_ARMED;
            len_q   <= cfg_length;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            fresh_q <= 1'b1;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_ARMED: begin
          // An edge seen together with the arm belongs to the arm.
          fresh_q <= 1'b0;
          if (rise && !fresh_q) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (last_pair) begin
            state_q <= S_DONE;
            if (!can_wr) begin
              pend_q <= 1'b1;
              last_q <= pair;
            end
          end else if (!can_wr) begin
            ovf_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (pend_wr) pend_q <= 1'b0;
          if (rd_en && head[AXIS_TDATA_WIDTH]) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign adc_csn       = 1'b1;
  assign m_axis_tvalid = ~empty;
  assign m_axis_tdata  = empty ? '0 : head[AXIS_TDATA_WIDTH-1:0];
  assign m_axis_tlast  = ~empty & head[AXIS_TDATA_WIDTH];
  assign busy          = busy_q;
  assign overflow      = ovf_q;

endmodule
